// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx
//   Memory-mapped UART transmitter sitting on the CPU memory bus next to main
//   memory. Two word registers at BASE_ADDR:
//     BASE_ADDR + 0 : DATA   (write pushes a byte into the TX FIFO, reads 0)
//     BASE_ADDR + 4 : STATUS (bit2 full, bit3 empty, bit4 busy, bit5 ovf;
//                             writing 1 to bit5 clears ovf)
//   Bytes are buffered in a 2^FIFO_AW deep FIFO and serialised LSB first on
//   tx as 8N1 frames. Consecutive frames follow each other with no idle gap.
//   Compile-time option: define UART_TX_PARITY_EN to insert an even parity
//   bit between the data bits and the stop bit (8E1 framing).
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_AW      = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] address,
  input  logic [31:0] memory_in,
  input  logic        write_enable,
  output logic [31:0] memory_out,
  output logic        read_capable,
  output logic        write_capable,
  output logic        tx
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  // Word addresses of the two registers.
  localparam logic [29:0] DATA_WADDR = BASE_ADDR[31:2];
  localparam logic [29:0] STAT_WADDR = BASE_ADDR[31:2] + 30'd1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;
`endif

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic hit_data;
  logic hit_stat;
  logic data_wr;
  logic stat_wr;

  assign hit_data      = (address == DATA_WADDR);
  assign hit_stat      = (address == STAT_WADDR);
  assign data_wr       = hit_data & write_enable;
  assign stat_wr       = hit_stat & write_enable;
  assign read_capable  = hit_data | hit_stat;
  assign write_capable = hit_data | hit_stat;

  // Only the low byte and the ovf-clear bit of the write data matter.
  logic unused_wdata;
  assign unused_wdata = &{1'b0, memory_in[31:8]};

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]       fifo_mem [DEPTH];
  logic [7:0]       head;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  // Extra MSB on each pointer distinguishes full from empty.
  assign full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                 (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  // full is the pre-edge value, so a same-cycle pop never makes room.
  assign push  = data_wr & ~full;
  assign head  = fifo_mem[rd_ptr_q[FIFO_AW-1:0]];

  // Pointer next-state: advance on push/pop, wrap through the extra MSB.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers; reset empties the FIFO.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block ordering.
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage has no reset; equal pointers mark it empty, so stale
    // contents are never observed and the array can map to plain RAM.
    if (push) fifo_mem[wr_ptr_q[FIFO_AW-1:0]] <= memory_in[7:0];
  end

  // ---------------------------------------------------------------------------
  // Overflow flag
  // ---------------------------------------------------------------------------
  logic ovf_q, ovf_d;

  // Sticky overflow: set by a DATA write into a full FIFO, cleared by software.
  always_comb begin
    ovf_d = ovf_q;
    if (data_wr && full)              ovf_d = 1'b1;
    else if (stat_wr && memory_in[5]) ovf_d = 1'b0;
  end

  // Overflow flag register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ovf_q <= 1'b0;
    else      ovf_q <= ovf_d;
  end

  // ---------------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             last_tick;
  logic             load;
  logic             busy;
`ifdef UART_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  assign last_tick = (cnt_q == CNT_LAST);
  assign busy      = (state_q != S_IDLE);
  assign tx        = tx_q;

  // Next-state logic; tx_d is the line level for the cycle after the edge,
  // which keeps tx a clean registered output.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    load    = 1'b0;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!empty) load = 1'b1;
      end

      S_START: begin
        if (last_tick) begin
          state_d = S_DATA;
          cnt_d   = '0;
          idx_d   = 3'd0;
          tx_d    = shift_q[0];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DATA: begin
        if (last_tick) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            tx_d    = parity_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
            tx_d  = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (last_tick) begin
          state_d = S_STOP;
          cnt_d   = '0;
          tx_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif

      S_STOP: begin
        if (last_tick) begin
          cnt_d = '0;
          if (!empty) begin
            // Next byte already waiting: straight into its start bit.
            load = 1'b1;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        tx_d    = 1'b1;
      end
    endcase

    // Frame start: pop the FIFO head into the shift register.
    if (load) begin
      pop     = 1'b1;
      shift_d = head;
      cnt_d   = '0;
      state_d = S_START;
      tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_d = ^head;
`endif
    end
  end

  // FSM registers; reset abandons any frame and forces the line idle high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      shift_q <= 8'd0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux (combinational, no side effects)
  // ---------------------------------------------------------------------------
  always_comb begin
    memory_out = 32'd0;
    if (hit_stat) memory_out = {26'd0, ovf_q, busy, empty, full, 2'd0};
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: a queue-based model predicts FIFO
// occupancy, the overflow flag and the serial waveform (frame bit = position
// in frame / CLKS_PER_BIT); one compare process checks every cycle, and
// hand-computed literals pin key instants.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          C     = 16;
  localparam int          DEPTH = 8;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * C;

  localparam logic [29:0] A_DATA = BASE[31:2];
  localparam logic [29:0] A_STAT = BASE[31:2] + 30'd1;
  localparam logic [29:0] A_NONE = BASE[31:2] + 30'd2;

  logic        clk = 1'b0;
  logic        rst;
  logic [29:0] address;
  logic [31:0] memory_in;
  logic        write_enable;
  logic [31:0] memory_out;
  logic        read_capable;
  logic        write_capable;
  logic        tx;

  int errors = 0;
  int checks = 0;
  bit check_en = 1'b0;

  mmio_uart_tx #(
    .BASE_ADDR   (BASE),
    .CLKS_PER_BIT(C),
    .FIFO_AW     (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .address      (address),
    .memory_in    (memory_in),
    .write_enable (write_enable),
    .memory_out   (memory_out),
    .read_capable (read_capable),
    .write_capable(write_capable),
    .tx           (tx)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]       m_q[$];
  bit               m_ovf    = 1'b0;
  bit               m_active = 1'b0;
  int               m_pos    = 0;
  logic [NBITS-1:0] m_bits   = '1;
  int               m_pre;
  bit               m_full_pre;

  function automatic logic [NBITS-1:0] frame_of(input logic [7:0] b);
    logic [NBITS-1:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1+i] = b[i];
`ifdef UART_TX_PARITY_EN
    f[9] = ^b;
`endif
    return f;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q.delete();
      m_ovf    = 1'b0;
      m_active = 1'b0;
      m_pos    = 0;
    end else begin
      m_pre      = m_q.size();
      m_full_pre = (m_pre == DEPTH);
      if (m_active) begin
        m_pos++;
        if (m_pos == FRAME) m_active = 1'b0;
      end
      if (!m_active && m_pre > 0) begin
        m_bits   = frame_of(m_q.pop_front());
        m_active = 1'b1;
        m_pos    = 0;
      end
      if (write_enable && address == A_DATA) begin
        if (m_full_pre) m_ovf = 1'b1;
        else            m_q.push_back(memory_in[7:0]);
      end
      if (write_enable && address == A_STAT && memory_in[5]) m_ovf = 1'b0;
    end
  end

  // ---------------- per-cycle compare ----------------
  logic        e_tx;
  logic [31:0] e_status;
  logic [31:0] e_rd;
  logic        e_cap;

  always @(negedge clk) begin
    if (check_en) begin
      e_tx     = m_active ? m_bits[m_pos / C] : 1'b1;
      e_status = {26'd0, m_ovf, m_active, (m_q.size() == 0), (m_q.size() == DEPTH), 2'b00};
      e_cap    = (address == A_DATA) || (address == A_STAT);
      e_rd     = (address == A_STAT) ? e_status : 32'd0;
      check("cyc_tx", tx, e_tx);
      check("cyc_memory_out", memory_out, e_rd);
      check("cyc_read_capable", read_capable, e_cap);
      check("cyc_write_capable", write_capable, e_cap);
    end
  end

  // ---------------- stimulus helpers ----------------
  // Inputs change 2 time units after a rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic bus_write(input logic [29:0] a, input logic [31:0] d);
    address      = a;
    memory_in    = d;
    write_enable = 1'b1;
    tick();
    write_enable = 1'b0;
    address      = A_STAT;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while (memory_out !== 32'h08 && n < budget) begin
      tick();
      n++;
    end
    #1;
    check(name, memory_out, 32'h08);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [29:0] ra;
    int          r;
    rst          = 1'b0;
    address      = A_STAT;
    memory_in    = 32'd0;
    write_enable = 1'b0;
    check_en     = 1'b1;

    // Reset state.
    repeat (3) tick();
    #1;
    check("reset_tx", tx, 1'b1);
    check("reset_status", memory_out, 32'h08);
    tick();
    rst     = 1'b1;
    address = A_NONE;
    #1;
    check("miss_read_capable", read_capable, 1'b0);
    check("miss_write_capable", write_capable, 1'b0);
    check("miss_memory_out", memory_out, 32'd0);
    address = A_DATA;
    #1;
    check("data_read_zero", memory_out, 32'd0);
    address = A_STAT;
    tick();

    // Single frame 0x55: latency, bit timing, busy and drain.
    bus_write(A_DATA, 32'h55);          // edge N
    tick(); #1;                          // N+1
    check("f55_start", tx, 1'b0);
    check("f55_status_busy", memory_out, 32'h18);
    repeat (16) tick(); #1;              // N+17
    check("f55_bit0", tx, 1'b1);
    repeat (16) tick(); #1;              // N+33
    check("f55_bit1", tx, 1'b0);
    repeat (111) tick(); #1;             // N+144
    check("f55_bit7", tx, 1'b0);
    tick(); #1;                          // N+145
`ifdef UART_TX_PARITY_EN
    check("f55_parity", tx, 1'b0);
`else
    check("f55_stop", tx, 1'b1);
`endif
    repeat (FRAME - 145) tick(); #1;     // N+FRAME
    check("f55_last_busy", memory_out, 32'h18);
    tick(); #1;                          // N+FRAME+1
    check("f55_idle", memory_out, 32'h08);

`ifdef UART_TX_PARITY_EN
    // Parity bit values and 11-bit frame length.
    bus_write(A_DATA, 32'h07);
    repeat (145) tick(); #1;
    check("p07_parity", tx, 1'b1);
    repeat (31) tick(); #1;              // N+176
    check("p07_last_busy", memory_out, 32'h18);
    tick(); #1;
    check("p07_idle", memory_out, 32'h08);
    bus_write(A_DATA, 32'h03);
    repeat (145) tick(); #1;
    check("p03_parity", tx, 1'b0);
    wait_idle(2 * FRAME, "p03_drain");
`endif

    // Burst: fill, overflow, clear.
    for (int i = 0; i < 9; i++) bus_write(A_DATA, i);
    #1;
    check("burst_full", memory_out, 32'h14);
    bus_write(A_DATA, 32'h09);
    #1;
    check("burst_ovf", memory_out, 32'h34);
    bus_write(A_STAT, 32'h20);
    #1;
    check("burst_ovf_clear", memory_out, 32'h14);
    wait_idle(10 * FRAME + 20, "burst_drain");

    // Back-to-back frames: STOP goes straight to START.
    bus_write(A_DATA, 32'hA5);          // edge N
    bus_write(A_DATA, 32'h3C);          // edge N+1
    repeat (FRAME - 1) tick(); #1;       // N+FRAME
    check("b2b_stop", tx, 1'b1);
    check("b2b_queued", memory_out, 32'h10);
    tick(); #1;                          // N+FRAME+1
    check("b2b_start", tx, 1'b0);
    check("b2b_busy_empty", memory_out, 32'h18);
    wait_idle(2 * FRAME + 20, "b2b_drain");

    // Async reset mid-DATA of 0xFF with 3 bytes queued.
    bus_write(A_DATA, 32'hFF);
    bus_write(A_DATA, 32'h11);
    bus_write(A_DATA, 32'h22);
    bus_write(A_DATA, 32'h33);
    repeat (40) tick(); #1;
    rst = 1'b0;
    #1;
    check("rst_mid_tx", tx, 1'b1);
    check("rst_mid_status", memory_out, 32'h08);
    tick(); tick();
    rst = 1'b1;
    repeat (200) tick(); #1;
    check("rst_no_frames_tx", tx, 1'b1);
    check("rst_no_frames_status", memory_out, 32'h08);

    // Async reset during a start bit: line must jump high at once.
    bus_write(A_DATA, 32'h00);
    tick(); #1;
    check("rst_start_low", tx, 1'b0);
    rst = 1'b0;
    #1;
    check("rst_start_async", tx, 1'b1);
    tick();
    rst = 1'b1;
    tick();

    // Randomised traffic against the model.
    for (int it = 0; it < 3000; it++) begin
      r = $urandom_range(0, 99);
      case ($urandom_range(0, 3))
        0:       ra = A_DATA - 30'd1;
        1:       ra = A_NONE;
        2:       ra = 30'($urandom);
        default: ra = A_DATA;
      endcase
      if (it == 1500) begin
        #1;
        rst = 1'b0;
        tick(); tick();
        rst = 1'b1;
      end else if (r < 14) begin
        bus_write(A_DATA, $urandom);
      end else if (r < 17) begin
        bus_write(A_STAT, $urandom);
      end else if (r < 20) begin
        bus_write(ra, $urandom);
      end else begin
        address   = (r < 60) ? A_STAT : ra;
        memory_in = $urandom;
        tick();
        address   = A_STAT;
      end
    end
    bus_write(A_STAT, 32'h20);
    wait_idle((DEPTH + 2) * FRAME, "random_drain");

    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
